// File: rtl/ahb_ext_subordinate_pkg.sv
// Shared definitions for the external-port AHB-Lite responder.
package ahb_ext_subordinate_pkg;

    // HTRANS encodings
    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} ahbsub_state_t;

    // {HREADYOUT, HRESP} presented while sitting in a given state
    function automatic logic [1:0] state_outputs(input ahbsub_state_t s);
        case (s)
            WAIT:    return 2'b00;
            ERR1:    return 2'b01;
            ERR2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/ahb_ext_ram_array.sv
// Word-addressed RAM: byte-strobed synchronous write, asynchronous read.
// Each byte lane is its own array so a strobe maps directly to a lane enable.
module ahb_ext_ram_array #(
    parameter int AHBW  = 64,
    parameter int DEPTH = 512,
    parameter int IDX_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [AHBW/8-1:0] wstrb,
    input  logic [AHBW-1:0]   wdata,
    output logic [AHBW-1:0]   rdata
);

    for (genvar i = 0; i < AHBW/8; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        // commit this byte lane only when its strobe is set
        always_ff @(posedge clk) begin
            if (we && wstrb[i]) lane_mem[addr] <= wdata[8*i +: 8];
        end

        assign rdata[8*i +: 8] = lane_mem[addr];
    end

endmodule

// File: rtl/ahb_ext_subordinate.sv
// AHB-Lite responder terminating the external port: internal RAM,
// programmable wait states, two-cycle ERROR for bad address or size.
module ahb_ext_subordinate
    import ahb_ext_subordinate_pkg::*;
#(
    parameter int                 AHBW        = 64,
    parameter int                 PA_BITS     = 56,
    parameter logic [PA_BITS-1:0] BASE        = 'h8000_0000,
    parameter logic [PA_BITS-1:0] RANGE       = 'h0000_0FFF,
    parameter int                 WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               HSEL,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [2:0]         HBURST,
    input  logic [1:0]         HTRANS,
    input  logic [3:0]         HPROT,
    input  logic               HMASTLOCK,
    input  logic               HREADY,
    input  logic [AHBW-1:0]    HWDATA,
    input  logic [AHBW/8-1:0]  HWSTRB,
    output logic [AHBW-1:0]    HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP
);

    localparam int NBYTES    = AHBW / 8;
    localparam int BYTE_BITS = $clog2(NBYTES);
    localparam int WIN_BITS  = $clog2(RANGE + 1);
    localparam int IDX_W     = (WIN_BITS > BYTE_BITS) ? WIN_BITS - BYTE_BITS : 1;
    localparam int DEPTH     = int'((RANGE + 1) / NBYTES);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    ahbsub_state_t      state, next_state, launch_state;
    logic [3:0]         wait_cnt;
    logic [IDX_W-1:0]   idx_q;
    logic               write_q;
    logic               hreadyout_q, hresp_q;
    logic               take_addr;
    logic [PA_BITS-1:0] offset;
    logic               accept, addr_err, size_err;
    logic               mem_we;
    logic [AHBW-1:0]    mem_rdata;

    // burst type, protection, lock and the BUSY/SEQ distinction carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign offset   = HADDR - BASE;
    assign accept   = HSEL & HREADY & HTRANS[1];
    assign addr_err = (HADDR < BASE) | (offset > RANGE);
    assign size_err = HSIZE > 3'(BYTE_BITS);

    // where an address phase accepted this cycle sends the FSM
    always_comb begin
        launch_state = IDLE;
        if (accept) begin
            if (addr_err | size_err)  launch_state = ERR1;
            else if (WAIT_STATES > 0) launch_state = WAIT;
            else                      launch_state = DATA;
        end
    end

    // next state; IDLE, DATA and ERR2 are the cycles where HREADYOUT is high
    always_comb begin
        next_state = state;
        take_addr  = 1'b0;
        case (state)
            IDLE, DATA, ERR2: begin
                next_state = launch_state;
                take_addr  = accept;
            end
            WAIT:    if (wait_cnt == 4'd0) next_state = DATA;
            ERR1:    next_state = ERR2;
            default: next_state = IDLE;
        endcase
    end

    // FSM state, wait counter, captured address phase and registered responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state                  <= next_state;
            {hreadyout_q, hresp_q} <= state_outputs(next_state);
            if (take_addr) begin
                idx_q    <= offset[BYTE_BITS +: IDX_W];
                write_q  <= HWRITE;
                wait_cnt <= WS_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // writes land at the end of the DATA cycle, so a read pipelined right
    // behind sees the new data without any bypass
    assign mem_we = (state == DATA) & write_q & ~reset;

    ahb_ext_ram_array #(
        .AHBW (AHBW),
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (mem_we),
        .addr (idx_q),
        .wstrb(HWSTRB),
        .wdata(HWDATA),
        .rdata(mem_rdata)
    );

    assign HRDATA    = (state == DATA && !write_q) ? mem_rdata : '0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: doc/ahb_ext_subordinate.md
Name: ahb_ext_subordinate

Overview:
- AHB-Lite subordinate that terminates the SoC's external AHB port: responds to HSELEXT transfers with HREADYEXT, HRESPEXT and HRDATAEXT, replacing the constant tie-offs on that port.
- Backed by a word-addressed internal RAM, with a programmable number of wait states and a two-cycle ERROR response.
- Used in lint/sim wrappers and in FPGA builds without external memory.

Parameters:
- AHBW, 64, data bus width in bits (32 or 64).
- PA_BITS, 56, physical address width.
- BASE, 'h8000_0000, base address of the responder window.
- RANGE, 'h0000_0FFF, window size minus one; must be 2^k-1 and at least AHBW/8-1.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before every data phase completes (0..15).

Ports:
- clk  in  1  clock (HCLK domain).
- reset  in  1  synchronous, active-high reset.
- HSEL  in  1  subordinate select (HSELEXT).
- HADDR  in  PA_BITS  address-phase address.
- HWRITE  in  1  address-phase write flag.
- HSIZE  in  3  address-phase transfer size.
- HBURST  in  3  burst type; ignored, since each beat is a separate NONSEQ/SEQ address phase.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready (muxed HREADY).
- HWDATA  in  AHBW  data-phase write data.
- HWSTRB  in  AHBW/8  data-phase byte strobes.
- HRDATA  out  AHBW  read data.
- HREADYOUT  out  1  subordinate ready (drives HREADYEXT).
- HRESP  out  1  0=OKAY, 1=ERROR (drives HRESPEXT).

Behaviour:
- Accept an address phase when HSEL & HREADY & HTRANS[1]. Register the word index ((HADDR-BASE)>>log2(AHBW/8)), HWRITE and an error flag.
- The error flag is set when the address is outside [BASE, BASE+RANGE] or HSIZE > log2(AHBW/8).
- IDLE/BUSY transfers, or transfers with HSEL=0, start no data phase. The subordinate stays HREADYOUT=1, HRESP=0.
- State machine, using state type ahbsub_state_t:
  - IDLE → WAIT on an accepted non-error transfer when WAIT_STATES>0.
  - IDLE → DATA on an accepted non-error transfer when WAIT_STATES=0.
  - IDLE → ERR1 on an accepted error transfer.
  - WAIT: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES-1 and decrements; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0. The transfer completes this cycle. If a new transfer is accepted in the same cycle (pipelined back-to-back), go to WAIT/DATA/ERR1 per the rules above; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. Next state follows the same rules as DATA. A manager that cancels by driving IDLE in ERR2 simply returns to IDLE.
- Latency: the data phase lasts WAIT_STATES+1 cycles, and 2 cycles for ERROR. Zero-wait back-to-back beats sustain one transfer per cycle.
- Write commit: on the DATA cycle, for each byte lane i with HWSTRB[i]=1, mem[idx] byte i ← HWDATA byte i. HSIZE is not re-decoded; the strobes are authoritative.
- Read: HRDATA = mem[idx] combinationally in the DATA cycle of a read; otherwise HRDATA = 0.
- Read-after-write: a write whose DATA cycle coincides with the next read's address phase commits at the clock edge, before that read's DATA cycle. The read therefore returns the new data, with no bypass needed.
- IDLE with HREADYOUT=1 is the only state in which a new address phase may arrive while no data phase is in flight.
- Reset:
  - Outputs: HREADYOUT=1, HRESP=0, HRDATA=0.
  - State → IDLE and the counter clears.
  - The memory array is not reset; its contents are undefined until written.
  - Reset mid-WAIT aborts the transfer, and a pending write is not committed.
- Address arithmetic: the subtraction is PA_BITS wide; the index uses bits [log2(RANGE+1)-1 : log2(AHBW/8)].

Decomposition:
- Shared package (cvw):
  - HTRANS encodings as localparams (AHB_IDLE, AHB_BUSY, AHB_NONSEQ, AHB_SEQ).
  - typedef enum logic [2:0] ahbsub_state_t {IDLE, WAIT, DATA, ERR1, ERR2}.
- One sub-module: ahb_ext_ram_array, holding (RANGE+1)/(AHBW/8) words × AHBW bits, with a byte-strobed synchronous write and an asynchronous read.
- The FSM, wait counter and address/range decode stay in the top module.

Test Plan:
- WAIT_STATES=0: NONSEQ write 0x8000_0010, HWDATA=0x1122334455667788, HWSTRB=0xFF; NONSEQ read of the same address on the next cycle → HREADYOUT held 1 throughout, HRDATA=0x1122334455667788 in the read data phase, HRESP=0.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, high on the 4th with data valid; a back-to-back second read adds another 3+1 cycles.
- Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF with HWSTRB=0xFF, then write 0x0000_0000_00AB_0000 with HWSTRB=0x04 to 0x8000_0008 → readback 0xFFFF_FFFF_FFAB_FFFF.
- Out of range: read 0x8000_1000 → cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1, HRDATA=0. A following in-range read completes OKAY.
- INCR4 burst (NONSEQ then 3× SEQ at +8) writes with WAIT_STATES=1, then a burst read → 4 words returned in order, 2 cycles per beat, no ERROR.
- Reset asserted in the 2nd WAIT cycle of a write with WAIT_STATES=3 → the next cycle shows HREADYOUT=1, HRESP=0, HRDATA=0, and a subsequent read of that address returns the prior contents.
